ps_readout_ctrl: RTL and testbench
==================================

PS_READOUT_CTRL -- requirements
Module: ps_readout_ctrl

Interface
REQ-001 Parameter FIFO_WIDTH, default 36, SHALL set the width of the FIFO data word and of dout.
REQ-002 Parameter NDATA, default 10, SHALL set the number of FIFO words expected per acquisition.
REQ-003 Parameter START_LEN, default 4, SHALL set the start_pulse width in clock cycles (minimum 1).
REQ-004 Parameter GAP_CYC, default 16, SHALL set the idle cycles between consecutive acquisitions (0 allowed).
REQ-005 Parameter TIMEOUT, default 1024, SHALL set the maximum cycles without a FIFO word before abort.
REQ-006 Ports SHALL be, clock and reset first:
- clk_in  in  1  sole clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_start  in  1  one-cycle request to begin a run.
- cmd_stop  in  1  one-cycle request to end the run at the next acquisition boundary.
- n_frames  in  16  acquisitions per run, sampled at run start; 0 = continuous until cmd_stop.
- mode_cfg  in  1  datapath mode, sampled at run start.
- start_pulse  out  1  acquisition trigger to the serialiser datapath.
- mode  out  1  registered mode to the datapath, held for the whole run.
- fifo_empty  in  1  datapath FIFO empty flag.
- fifo_rd_en  out  1  FIFO read strobe; data appears on fifo_q one cycle later.
- fifo_q  in  FIFO_WIDTH  FIFO read data.
- dout  out  FIFO_WIDTH  output word.
- dout_valid  out  1  dout holds a valid word.
- dout_ready  in  1  downstream accepts dout when both valid and ready are high.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a run ends, normally or by abort.
- frame_cnt  out  16  completed acquisitions in the current run.
- err_timeout  out  1  sticky timeout flag.

Function
REQ-007 The FSM SHALL have states IDLE, PULSE, COLLECT, GAP and FINISH.
REQ-008 IDLE SHALL move to PULSE on cmd_start, latching n_frames and mode_cfg, clearing frame_cnt and err_timeout.
REQ-009 PULSE SHALL drive start_pulse high for exactly START_LEN cycles, then enter COLLECT with the word counter cleared.
REQ-010 In COLLECT, fifo_rd_en SHALL be high for one cycle only when fifo_empty=0, no read is in flight, and (dout_valid=0 or dout_ready=1).
REQ-011 The cycle after fifo_rd_en, fifo_q SHALL be registered into dout with dout_valid=1, and the word counter SHALL increment.
REQ-012 dout and dout_valid SHALL hold unchanged while dout_valid=1 and dout_ready=0; peak throughput is one word per two cycles.
REQ-013 When the NDATA-th word is registered, frame_cnt SHALL increment in that same cycle and the FSM SHALL leave COLLECT.
REQ-014 After an acquisition: if cmd_stop was seen during the run, or n_frames!=0 and frame_cnt equals n_frames, go to FINISH; otherwise go to GAP.
REQ-015 GAP SHALL last GAP_CYC cycles and then enter PULSE; with GAP_CYC=0 it SHALL pass straight to PULSE.
REQ-016 A timeout counter SHALL clear on PULSE entry and on every registered word; reaching TIMEOUT in COLLECT SHALL set err_timeout and enter FINISH.
REQ-017 FINISH SHALL wait until dout_valid=0, then pulse done for one cycle and return to IDLE.
REQ-018 cmd_start SHALL be ignored outside IDLE; cmd_stop SHALL be ignored in IDLE and latched (sticky until IDLE) elsewhere.
REQ-019 frame_cnt SHALL saturate at 16'hFFFF in continuous mode.
REQ-020 fifo_rd_en SHALL never be high while fifo_empty=1 or outside COLLECT.
REQ-021 mode SHALL change only on the IDLE->PULSE transition.

Reset
REQ-022 On rst=1, all of the following SHALL clear immediately and asynchronously, including mid-run: state to IDLE; start_pulse, fifo_rd_en, dout_valid, busy and done to 0; dout, frame_cnt and all counters to 0; err_timeout and mode to 0.
REQ-023 After rst is released, the first cmd_start SHALL be honoured on the next rising edge.

Verification
REQ-024 n_frames=1, FIFO model holding 10 words, dout_ready=1 -> start_pulse high for 4 cycles; exactly 10 dout beats in order; frame_cnt=1; done pulses once; busy low after.
REQ-025 n_frames=3, GAP_CYC=16 -> three start_pulses, 16 idle cycles between the end of one acquisition and the next start_pulse, 30 beats, frame_cnt=3.
REQ-026 dout_ready held low for 20 cycles mid-acquisition -> dout stable; fifo_rd_en stays low; no word lost or duplicated.
REQ-027 FIFO never fills after start_pulse -> err_timeout=1 at 1024 cycles after the start_pulse ends; done pulses; return to IDLE.
REQ-028 n_frames=0, cmd_stop during the 2nd acquisition -> the 2nd acquisition completes; no 3rd start_pulse; frame_cnt=2.
REQ-029 rst asserted during COLLECT -> all outputs 0 in the same cycle; a new cmd_start runs normally.

Source files
------------

// File: rtl/ps_readout_ctrl.sv
// Readout sequencer: fires acquisition triggers, drains the datapath FIFO into a
// valid/ready word stream, and bounds each run by frame count, stop request or timeout.
module ps_readout_ctrl #(
    parameter int FIFO_WIDTH = 36,
    parameter int NDATA      = 10,
    parameter int START_LEN  = 4,
    parameter int GAP_CYC    = 16,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic                  cmd_start,
    input  logic                  cmd_stop,
    input  logic [15:0]           n_frames,
    input  logic                  mode_cfg,
    output logic                  start_pulse,
    output logic                  mode,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [FIFO_WIDTH-1:0] fifo_q,
    output logic [FIFO_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           frame_cnt,
    output logic                  err_timeout
);

    localparam int PH_MAX = (START_LEN > GAP_CYC) ? START_LEN : GAP_CYC;
    localparam int PH_W   = $clog2(PH_MAX + 32'sd1);
    localparam int WC_W   = $clog2(NDATA + 32'sd1);
    localparam int TO_W   = $clog2(TIMEOUT + 32'sd1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PULSE   = 3'd1,
        ST_COLLECT = 3'd2,
        ST_GAP     = 3'd3,
        ST_FINISH  = 3'd4
    } state_t;

    state_t                  state_r;
    state_t                  next_state_s;
    logic [PH_W-1:0]         phase_cnt_r;
    logic [WC_W-1:0]         word_cnt_r;
    logic [TO_W-1:0]         tmo_cnt_r;
    logic                    rd_pend_r;
    logic                    stop_r;
    logic [15:0]             n_frames_r;
    logic [15:0]             frame_cnt_r;
    logic [15:0]             frame_inc_s;
    logic [FIFO_WIDTH-1:0]   dout_r;
    logic                    dout_valid_r;
    logic                    err_timeout_r;
    logic                    mode_r;
    logic                    start_pulse_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    fifo_rd_en_s;
    logic                    start_pulse_s;
    logic                    busy_s;
    logic                    done_s;
    logic                    last_word_s;
    logic                    timeout_s;
    logic                    run_over_s;

    // The last word of an acquisition is the one landing in dout this cycle.
    assign last_word_s = (state_r == ST_COLLECT) && rd_pend_r &&
                         (word_cnt_r == WC_W'(NDATA - 32'sd1));
    assign timeout_s   = (state_r == ST_COLLECT) && !rd_pend_r &&
                         (tmo_cnt_r == TO_W'(TIMEOUT - 32'sd1));
    assign frame_inc_s = (frame_cnt_r == 16'hFFFF) ? 16'hFFFF : (frame_cnt_r + 16'd1);
    assign run_over_s  = stop_r || cmd_stop ||
                         ((n_frames_r != 16'd0) && (frame_inc_s == n_frames_r));

    // FSM state register
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_start) next_state_s = ST_PULSE;
                else           next_state_s = ST_IDLE;
            end
            ST_PULSE: begin
                if (phase_cnt_r == PH_W'(START_LEN - 32'sd1)) next_state_s = ST_COLLECT;
                else                                          next_state_s = ST_PULSE;
            end
            ST_COLLECT: begin
                if (last_word_s) begin
                    if (run_over_s)                  next_state_s = ST_FINISH;
                    else if (GAP_CYC == 32'sd0)      next_state_s = ST_PULSE;
                    else                             next_state_s = ST_GAP;
                end else if (timeout_s) begin
                    next_state_s = ST_FINISH;
                end else begin
                    next_state_s = ST_COLLECT;
                end
            end
            ST_GAP: begin
                if (phase_cnt_r == PH_W'(GAP_CYC - 32'sd1)) next_state_s = ST_PULSE;
                else                                        next_state_s = ST_GAP;
            end
            ST_FINISH: begin
                if (!dout_valid_r) next_state_s = ST_IDLE;
                else               next_state_s = ST_FINISH;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // FSM outputs; the read strobe stays combinational so it never races fifo_empty
    always_comb begin
        fifo_rd_en_s  = (state_r == ST_COLLECT) && !fifo_empty && !rd_pend_r &&
                        (!dout_valid_r || dout_ready) && !timeout_s;
        start_pulse_s = (next_state_s == ST_PULSE);
        busy_s        = (next_state_s != ST_IDLE);
        done_s        = (state_r == ST_FINISH) && (next_state_s == ST_IDLE);
    end

    // Registered status outputs, aligned with the state they describe
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            start_pulse_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            start_pulse_r <= start_pulse_s;
            busy_r        <= busy_s;
            done_r        <= done_s;
        end
    end

    // Phase, word and timeout counters
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            phase_cnt_r <= '0;
            word_cnt_r  <= '0;
            tmo_cnt_r   <= '0;
        end else begin
            if ((next_state_s != state_r) || ((state_r != ST_PULSE) && (state_r != ST_GAP)))
                phase_cnt_r <= '0;
            else
                phase_cnt_r <= phase_cnt_r + PH_W'(1);
            if (state_r != ST_COLLECT)
                word_cnt_r <= '0;
            else if (rd_pend_r)
                word_cnt_r <= word_cnt_r + WC_W'(1);
            if ((state_r != ST_COLLECT) || rd_pend_r)
                tmo_cnt_r <= '0;
            else
                tmo_cnt_r <= tmo_cnt_r + TO_W'(1);
        end
    end

    // Run context: configuration latched at start, frame count, stop and timeout flags
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            n_frames_r    <= 16'd0;
            mode_r        <= 1'b0;
            frame_cnt_r   <= 16'd0;
            err_timeout_r <= 1'b0;
            stop_r        <= 1'b0;
        end else begin
            if ((state_r == ST_IDLE) && cmd_start) begin
                n_frames_r    <= n_frames;
                mode_r        <= mode_cfg;
                frame_cnt_r   <= 16'd0;
                err_timeout_r <= 1'b0;
            end else begin
                if (last_word_s) frame_cnt_r <= frame_inc_s;
                if (timeout_s)   err_timeout_r <= 1'b1;
            end
            if (state_r == ST_IDLE)
                stop_r <= 1'b0;
            else if (cmd_stop)
                stop_r <= 1'b1;
        end
    end

    // Output word register: load on returning read, release on handshake
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            rd_pend_r    <= 1'b0;
            dout_r       <= '0;
            dout_valid_r <= 1'b0;
        end else begin
            rd_pend_r <= fifo_rd_en_s;
            if (rd_pend_r) begin
                dout_r       <= fifo_q;
                dout_valid_r <= 1'b1;
            end else if (dout_valid_r && dout_ready) begin
                dout_valid_r <= 1'b0;
            end
        end
    end

    assign start_pulse = start_pulse_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign fifo_rd_en  = fifo_rd_en_s;
    assign dout        = dout_r;
    assign dout_valid  = dout_valid_r;
    assign mode        = mode_r;
    assign frame_cnt   = frame_cnt_r;
    assign err_timeout = err_timeout_r;

endmodule

// File: tb/tb_ps_readout_ctrl.sv
// Bench for ps_readout_ctrl: FIFO model, stream monitor and per-scenario checks
// against a queue-based reference of pushed words and run rules.
module tb_ps_readout_ctrl;
    localparam int W         = 36;
    localparam int NDATA     = 10;
    localparam int START_LEN = 4;
    localparam int GAP_CYC   = 16;
    localparam int TIMEOUT   = 1024;

    logic          clk_in = 1'b0;
    logic          rst, cmd_start, cmd_stop, mode_cfg, dout_ready;
    logic [15:0]   n_frames;
    logic          start_pulse, mode, fifo_empty, fifo_rd_en, dout_valid;
    logic          busy, done, err_timeout;
    logic [W-1:0]  fifo_q = '0;
    logic [W-1:0]  dout;
    logic [15:0]   frame_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_in = ~clk_in;

    ps_readout_ctrl #(.FIFO_WIDTH(W), .NDATA(NDATA), .START_LEN(START_LEN),
                      .GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)) dut (
        .clk_in(clk_in), .rst(rst), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
        .n_frames(n_frames), .mode_cfg(mode_cfg), .start_pulse(start_pulse),
        .mode(mode), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .fifo_q(fifo_q), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .busy(busy), .done(done),
        .frame_cnt(frame_cnt), .err_timeout(err_timeout));

    // FIFO model: one-cycle read latency
    logic [W-1:0] fifo_mem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk_in) begin
        if (fifo_rd_en && (rd_ptr != wr_ptr)) begin
            fifo_q <= fifo_mem[rd_ptr % 1024];
            rd_ptr <= rd_ptr + 1;
        end
    end

    // Stream monitor, sampled on the falling edge
    logic [W-1:0] got_q [$];
    int word_cyc_q [$];
    int sp_rise_q [$];
    int sp_fall_q [$];
    int cyc = 0, done_cnt = 0, rd_viol = 0, hold_viol = 0, err_rise_cyc = -1;
    logic sp_prev = 1'b0, err_prev = 1'b0, dv_prev = 1'b0, rdy_prev = 1'b0;
    logic [W-1:0] dout_prev = '0;

    always @(negedge clk_in) begin
        cyc <= cyc + 1;
        if (dout_valid && dout_ready) got_q.push_back(dout);
        if (dout_valid && !dv_prev) word_cyc_q.push_back(cyc);
        if (start_pulse && !sp_prev) sp_rise_q.push_back(cyc);
        if (!start_pulse && sp_prev) sp_fall_q.push_back(cyc);
        if (err_timeout && !err_prev) err_rise_cyc <= cyc;
        if (done) done_cnt <= done_cnt + 1;
        if (fifo_rd_en && (fifo_empty || !busy)) rd_viol <= rd_viol + 1;
        if (!rst && dv_prev && !rdy_prev && (!dout_valid || dout !== dout_prev))
            hold_viol <= hold_viol + 1;
        sp_prev   <= start_pulse;
        err_prev  <= err_timeout;
        dv_prev   <= dout_valid;
        rdy_prev  <= dout_ready;
        dout_prev <= dout;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic push_word(output logic [W-1:0] w);
        w = {4'($urandom()), 32'($urandom())};
        fifo_mem[wr_ptr % 1024] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic start_run(input logic [15:0] nf, input logic md);
        n_frames  = nf;
        mode_cfg  = md;
        cmd_start = 1'b1;
        tick(1);
        cmd_start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, input string tag);
        int k = 0;
        while (done_cnt == d0 && k < budget) begin
            tick(1);
            k++;
        end
        if (done_cnt == d0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_wait_done: done count %0d, required %0d within %0d cycles",
                     tag, done_cnt - d0, 1, budget);
        end
        tick(2);
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_start = 1'b0; cmd_stop = 1'b0; n_frames = 16'd0;
        mode_cfg = 1'b0; dout_ready = 1'b1;
        tick(3);
        n_cmp++;
        if ({start_pulse, mode, fifo_rd_en, dout_valid, busy, done, err_timeout} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b required 0000000",
                     {start_pulse, mode, fifo_rd_en, dout_valid, busy, done, err_timeout});
        end
        n_cmp++;
        if (dout !== '0 || frame_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_data: dout=%h frame_cnt=%0d required 0/0", dout, frame_cnt);
        end
        rst = 1'b0;
        tick(2);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle_busy: got %b required 0", busy);
        end
    endtask

    task automatic test_single();
        logic [W-1:0] exp_q [$];
        logic [W-1:0] w;
        logic md;
        int g0, r0, f0, d0, errs;
        md = 1'($urandom_range(0, 1));
        for (int i = 0; i < NDATA; i++) begin
            push_word(w);
            exp_q.push_back(w);
        end
        g0 = got_q.size(); r0 = sp_rise_q.size(); f0 = sp_fall_q.size(); d0 = done_cnt;
        dout_ready = 1'b1;
        start_run(16'd1, md);
        n_cmp++;
        if (start_pulse !== 1'b1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL single_start_latency: start_pulse=%b busy=%b required 1/1", start_pulse, busy);
        end
        n_cmp++;
        if (mode !== md) begin
            n_bad++;
            $display("FAIL single_mode: got %b required %b", mode, md);
        end
        wait_done(d0, 300, "single");
        n_cmp++;
        if (got_q.size() - g0 != NDATA) begin
            n_bad++;
            $display("FAIL single_beats: got %0d required %0d", got_q.size() - g0, NDATA);
        end
        errs = 0;
        for (int i = 0; i < NDATA && g0 + i < got_q.size(); i++)
            if (got_q[g0 + i] !== exp_q[i]) errs++;
        n_cmp++;
        if (errs != 0) begin
            n_bad++;
            $display("FAIL single_order: %0d words differ, required 0", errs);
        end
        n_cmp++;
        if (sp_rise_q.size() - r0 != 1 || sp_fall_q.size() <= f0 ||
            sp_fall_q[f0] - sp_rise_q[r0] != START_LEN) begin
            n_bad++;
            $display("FAIL single_pulse: rises=%0d required 1, width required %0d",
                     sp_rise_q.size() - r0, START_LEN);
        end
        n_cmp++;
        if (frame_cnt !== 16'd1 || done_cnt - d0 != 1 || busy !== 1'b0 || err_timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL single_end: frame_cnt=%0d dones=%0d busy=%b err=%b required 1/1/0/0",
                     frame_cnt, done_cnt - d0, busy, err_timeout);
        end
    endtask

    task automatic test_multi();
        logic [W-1:0] exp_q [$];
        logic [W-1:0] w;
        int g0, r0, w0, d0, errs;
        cmd_stop = 1'b1;
        tick(1);
        cmd_stop = 1'b0;
        for (int i = 0; i < 3 * NDATA; i++) begin
            push_word(w);
            exp_q.push_back(w);
        end
        g0 = got_q.size(); r0 = sp_rise_q.size(); w0 = word_cyc_q.size(); d0 = done_cnt;
        dout_ready = 1'b1;
        start_run(16'd3, 1'b0);
        tick(30);
        cmd_start = 1'b1;
        tick(1);
        cmd_start = 1'b0;
        wait_done(d0, 600, "multi");
        errs = 0;
        for (int i = 0; i < 3 * NDATA && g0 + i < got_q.size(); i++)
            if (got_q[g0 + i] !== exp_q[i]) errs++;
        n_cmp++;
        if (got_q.size() - g0 != 3 * NDATA || errs != 0) begin
            n_bad++;
            $display("FAIL multi_beats: got %0d beats (%0d differ) required %0d (0)",
                     got_q.size() - g0, errs, 3 * NDATA);
        end
        n_cmp++;
        if (sp_rise_q.size() - r0 != 3) begin
            n_bad++;
            $display("FAIL multi_pulses: got %0d required 3", sp_rise_q.size() - r0);
        end
        for (int k = 1; k < 3; k++) begin
            n_cmp++;
            if (sp_rise_q.size() <= r0 + k || word_cyc_q.size() < w0 + k * NDATA ||
                sp_rise_q[r0 + k] - word_cyc_q[w0 + k * NDATA - 1] != GAP_CYC) begin
                n_bad++;
                $display("FAIL multi_gap%0d: gap wrong, required %0d cycles", k, GAP_CYC);
            end
        end
        n_cmp++;
        if (frame_cnt !== 16'd3) begin
            n_bad++;
            $display("FAIL multi_frame_cnt: got %0d required 3", frame_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] exp_q [$];
        logic [W-1:0] w, held;
        int g0, d0, h0, k, errs, unstable, rd_seen;
        bit found;
        for (int i = 0; i < NDATA; i++) begin
            push_word(w);
            exp_q.push_back(w);
        end
        g0 = got_q.size(); d0 = done_cnt; h0 = hold_viol;
        dout_ready = 1'b1;
        start_run(16'd1, 1'b1);
        found = 1'b0; k = 0;
        while (!found && k < 200) begin
            tick(1);
            k++;
            if ((got_q.size() - g0) >= 3 && dout_valid === 1'b1) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL bp_reach: third beat not seen in %0d cycles", k);
        end
        dout_ready = 1'b0;
        held = dout;
        unstable = 0; rd_seen = 0;
        repeat (20) begin
            tick(1);
            if (dout !== held || dout_valid !== 1'b1) unstable++;
            if (fifo_rd_en !== 1'b0) rd_seen++;
        end
        n_cmp++;
        if (unstable != 0) begin
            n_bad++;
            $display("FAIL bp_stable: %0d unstable cycles, required 0", unstable);
        end
        n_cmp++;
        if (rd_seen != 0) begin
            n_bad++;
            $display("FAIL bp_no_read: fifo_rd_en high %0d cycles, required 0", rd_seen);
        end
        k = 0;
        while (done_cnt == d0 && k < 500) begin
            dout_ready = 1'($urandom_range(0, 1));
            tick(1);
            k++;
        end
        dout_ready = 1'b1;
        wait_done(d0, 50, "bp");
        errs = 0;
        for (int i = 0; i < NDATA && g0 + i < got_q.size(); i++)
            if (got_q[g0 + i] !== exp_q[i]) errs++;
        n_cmp++;
        if (got_q.size() - g0 != NDATA || errs != 0) begin
            n_bad++;
            $display("FAIL bp_words: got %0d beats (%0d differ) required %0d (0)",
                     got_q.size() - g0, errs, NDATA);
        end
        n_cmp++;
        if (hold_viol - h0 != 0) begin
            n_bad++;
            $display("FAIL bp_hold: %0d hold violations, required 0", hold_viol - h0);
        end
    endtask

    task automatic test_timeout();
        int g0, f0, d0;
        wr_ptr = rd_ptr;
        g0 = got_q.size(); f0 = sp_fall_q.size(); d0 = done_cnt;
        start_run(16'd1, 1'b0);
        wait_done(d0, TIMEOUT + 200, "timeout");
        n_cmp++;
        if (err_timeout !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_flag: got %b required 1", err_timeout);
        end
        n_cmp++;
        if (sp_fall_q.size() <= f0 || err_rise_cyc - sp_fall_q[f0] != TIMEOUT) begin
            n_bad++;
            $display("FAIL timeout_delay: got %0d required %0d", err_rise_cyc -
                     (sp_fall_q.size() > f0 ? sp_fall_q[f0] : 0), TIMEOUT);
        end
        n_cmp++;
        if (done_cnt - d0 != 1 || busy !== 1'b0 || got_q.size() != g0 || frame_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL timeout_end: dones=%0d busy=%b beats=%0d frame_cnt=%0d required 1/0/0/0",
                     done_cnt - d0, busy, got_q.size() - g0, frame_cnt);
        end
    endtask

    task automatic test_stop();
        logic [W-1:0] exp_q [$];
        logic [W-1:0] w;
        int g0, r0, w0, d0, k, errs;
        for (int i = 0; i < 4 * NDATA; i++) begin
            push_word(w);
            exp_q.push_back(w);
        end
        g0 = got_q.size(); r0 = sp_rise_q.size(); w0 = word_cyc_q.size(); d0 = done_cnt;
        dout_ready = 1'b1;
        start_run(16'd0, 1'b1);
        n_cmp++;
        if (err_timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL stop_err_cleared: got %b required 0", err_timeout);
        end
        k = 0;
        while (word_cyc_q.size() - w0 < NDATA + 3 && k < 300) begin
            tick(1);
            k++;
        end
        cmd_stop = 1'b1;
        tick(1);
        cmd_stop = 1'b0;
        wait_done(d0, 300, "stop");
        errs = 0;
        for (int i = 0; i < 2 * NDATA && g0 + i < got_q.size(); i++)
            if (got_q[g0 + i] !== exp_q[i]) errs++;
        n_cmp++;
        if (got_q.size() - g0 != 2 * NDATA || errs != 0) begin
            n_bad++;
            $display("FAIL stop_beats: got %0d beats (%0d differ) required %0d (0)",
                     got_q.size() - g0, errs, 2 * NDATA);
        end
        n_cmp++;
        if (sp_rise_q.size() - r0 != 2 || frame_cnt !== 16'd2) begin
            n_bad++;
            $display("FAIL stop_frames: pulses=%0d frame_cnt=%0d required 2/2",
                     sp_rise_q.size() - r0, frame_cnt);
        end
        wr_ptr = rd_ptr;
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] w;
        int g0, k;
        for (int i = 0; i < NDATA; i++) push_word(w);
        g0 = got_q.size();
        dout_ready = 1'b1;
        start_run(16'd1, 1'b1);
        k = 0;
        while (got_q.size() - g0 < 3 && k < 200) begin
            tick(1);
            k++;
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({start_pulse, mode, fifo_rd_en, dout_valid, busy, done, err_timeout} !== 7'b0 ||
            dout !== '0 || frame_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL midrun_reset: flags=%b dout=%h frame_cnt=%0d required all 0",
                     {start_pulse, mode, fifo_rd_en, dout_valid, busy, done, err_timeout},
                     dout, frame_cnt);
        end
        tick(2);
        rst = 1'b0;
        wr_ptr = rd_ptr;
        tick(1);
    endtask

    task automatic test_random();
        logic [W-1:0] exp_q [$];
        logic [W-1:0] w;
        logic [15:0] nf;
        logic md;
        int g0, r0, d0, k, errs;
        for (int it = 0; it < 3; it++) begin
            exp_q.delete();
            nf = 16'($urandom_range(1, 3));
            md = 1'($urandom_range(0, 1));
            for (int i = 0; i < int'(nf) * NDATA; i++) begin
                push_word(w);
                exp_q.push_back(w);
            end
            g0 = got_q.size(); r0 = sp_rise_q.size(); d0 = done_cnt;
            start_run(nf, md);
            k = 0;
            while (done_cnt == d0 && k < 2000) begin
                dout_ready = ($urandom_range(0, 3) != 0);
                tick(1);
                k++;
            end
            dout_ready = 1'b1;
            wait_done(d0, 50, "random");
            errs = 0;
            for (int i = 0; i < exp_q.size() && g0 + i < got_q.size(); i++)
                if (got_q[g0 + i] !== exp_q[i]) errs++;
            n_cmp++;
            if (got_q.size() - g0 != exp_q.size() || errs != 0) begin
                n_bad++;
                $display("FAIL random%0d_words: got %0d beats (%0d differ) required %0d (0)",
                         it, got_q.size() - g0, errs, exp_q.size());
            end
            n_cmp++;
            if (frame_cnt !== nf || sp_rise_q.size() - r0 != int'(nf) || mode !== md) begin
                n_bad++;
                $display("FAIL random%0d_run: frame_cnt=%0d pulses=%0d mode=%b required %0d/%0d/%b",
                         it, frame_cnt, sp_rise_q.size() - r0, mode, nf, nf, md);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_backpressure();
        test_timeout();
        test_stop();
        test_reset_mid_run();
        test_single();
        test_random();
        n_cmp++;
        if (rd_viol != 0) begin
            n_bad++;
            $display("FAIL rd_en_guard: %0d illegal reads, required 0", rd_viol);
        end
        n_cmp++;
        if (hold_viol != 0) begin
            n_bad++;
            $display("FAIL dout_hold: %0d hold violations, required 0", hold_viol);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
